// File: rtl/ccip_c1_tx_shaper.sv
// ---------------------------------------------------------------------------
// ccip_c1_tx_shaper
//
// Shapes the CCI-P c1 (write) TX stream between the transmitter and the
// platform. Write beats are buffered in a FIFO, held while the platform
// asserts almost-full, and released only when enough write credits remain
// to cover the whole multi-CL batch that the head beat starts. Credits are
// returned by c1 write responses (packed or unpacked).
//
// Ports:
//   clk              clock
//   resetn           asynchronous active-low reset
//   sTx_c1_in        write beats from the transmitter (valid, hdr, data)
//   in_ready         1 while at least SKID FIFO entries are free
//   sRx_c1TxAlmFull  platform c1 almost-full
//   sTx_c1           registered write beats to the platform
//   sRx_c1           c1 responses (rspValid, resp_type, format, cl_num)
//   outstanding_out  cache lines written but not yet acknowledged
//   wr_req_cnt       beats issued (wrapping)
//   wr_rsp_cnt       cache lines acknowledged (wrapping)
//   ovf_error        sticky: beat arrived while the FIFO was full
//   proto_error      sticky: non-sop beat at the head while idle, or sop
//                    beat inside a batch
//   udf_error        sticky: response would take outstanding below zero
// ---------------------------------------------------------------------------
package ccip_c1_tx_shaper_pkg;

  typedef enum logic [3:0] {
    eREQ_WRLINE_I = 4'h0,
    eREQ_WRLINE_M = 4'h1,
    eREQ_WRPUSH_I = 4'h2,
    eREQ_WRFENCE  = 4'h4
  } t_ccip_c1_req;

  typedef enum logic [3:0] {
    eRSP_WRLINE  = 4'h1,
    eRSP_WRFENCE = 4'h4,
    eRSP_INTR    = 4'h8
  } t_ccip_c1_rsp;

  typedef logic [511:0] t_ccip_clData;

  typedef struct packed {
    logic [1:0]   cl_len;
    logic         sop;
    t_ccip_c1_req req_type;
    logic [41:0]  address;
    logic [15:0]  mdata;
  } t_ccip_c1_ReqMemHdr;

  typedef struct packed {
    t_ccip_c1_ReqMemHdr hdr;
    t_ccip_clData       data;
    logic               valid;
  } t_if_ccip_c1_Tx;

  typedef struct packed {
    t_ccip_c1_ReqMemHdr hdr;
    t_ccip_clData       data;
  } t_c1_beat;

  typedef struct packed {
    t_ccip_c1_rsp resp_type;
    logic         format;
    logic [1:0]   cl_num;
  } t_ccip_c1_RspMemHdr;

  typedef struct packed {
    t_ccip_c1_RspMemHdr hdr;
    logic               rspValid;
  } t_if_ccip_c1_Rx;

endpackage

module ccip_c1_tx_shaper
  import ccip_c1_tx_shaper_pkg::*;
#(
  parameter int NIC_ID          = 0,
  parameter int LFIFO_DEPTH     = 4,
  parameter int SKID            = 4,
  parameter int MAX_OUTSTANDING = 64
) (
  input  logic                                 clk,
  input  logic                                 resetn,
  input  t_if_ccip_c1_Tx                       sTx_c1_in,
  output logic                                 in_ready,
  input  logic                                 sRx_c1TxAlmFull,
  output t_if_ccip_c1_Tx                       sTx_c1,
  input  t_if_ccip_c1_Rx                       sRx_c1,
  output logic [$clog2(MAX_OUTSTANDING):0]     outstanding_out,
  output logic [31:0]                          wr_req_cnt,
  output logic [31:0]                          wr_rsp_cnt,
  output logic                                 ovf_error,
  output logic                                 proto_error,
  output logic                                 udf_error
);

  localparam int DEPTH = 1 << LFIFO_DEPTH;
  localparam int CNT_W = LFIFO_DEPTH + 1;
  localparam int OUT_W = $clog2(MAX_OUTSTANDING) + 1;

  // Credit arithmetic below assumes a batch of up to 4 CLs always fits.
  if (MAX_OUTSTANDING < 4 || SKID > DEPTH || NIC_ID < 0) begin : g_bad_param
    $error("ccip_c1_tx_shaper: illegal parameter combination");
  end

  typedef enum logic {S_IDLE, S_BURST} t_state;

  // Clamp the credit update at zero; underflow is flagged separately.
  function automatic logic [OUT_W-1:0] floor_at_zero(input logic signed [OUT_W+1:0] v);
    if (v < 0) return '0;
    return v[OUT_W-1:0];
  endfunction

  // ---- stage p0: input capture -------------------------------------------
  logic     vld_p0;
  t_c1_beat beat_p0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) vld_p0 <= 1'b0;
    else         vld_p0 <= sTx_c1_in.valid;
  end

  always_ff @(posedge clk) begin
    if (sTx_c1_in.valid) begin
      beat_p0.hdr  <= sTx_c1_in.hdr;
      beat_p0.data <= sTx_c1_in.data;
    end
  end

  // ---- beat FIFO ----------------------------------------------------------
  t_c1_beat                mem [DEPTH];
  logic [LFIFO_DEPTH-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]        count;
  logic                    full, head_vld, push_ok, drop, pop;
  t_c1_beat                head;

  assign full     = (count == CNT_W'(DEPTH));
  assign head_vld = (count != '0);
  assign head     = mem[rd_ptr];
  assign in_ready = (count <= CNT_W'(DEPTH - SKID));
  // A pop in the same cycle frees the slot, so a push at full still lands.
  assign push_ok  = vld_p0 && (!full || pop);
  assign drop     = vld_p0 && full && !pop;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= beat_p0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // ---- issue control ------------------------------------------------------
  t_state           state, state_nxt;
  logic [1:0]       beats_left, beats_left_nxt;
  logic [OUT_W-1:0] outstanding;
  logic [2:0]       head_len, reserve, dec;
  logic [OUT_W:0]   credit_need;
  logic             credit_ok, issue, proto_set, rsp_wr;

  assign head_len    = {1'b0, head.hdr.cl_len} + 3'd1;
  assign credit_need = {1'b0, outstanding} + {{(OUT_W-2){1'b0}}, head_len};
  assign credit_ok   = (credit_need <= (OUT_W+1)'(MAX_OUTSTANDING));

  always_comb begin
    state_nxt      = state;
    beats_left_nxt = beats_left;
    issue          = 1'b0;
    pop            = 1'b0;
    reserve        = 3'd0;
    proto_set      = 1'b0;
    case (state)
      S_IDLE: begin
        if (head_vld) begin
          if (!head.hdr.sop) begin
            // Orphan continuation beat: discard so the stream can resync.
            pop       = 1'b1;
            proto_set = 1'b1;
          end else if (!sRx_c1TxAlmFull && credit_ok) begin
            // Reserve credits for the whole batch on its first beat so the
            // remaining beats can never stall on credits mid-batch.
            issue          = 1'b1;
            pop            = 1'b1;
            reserve        = head_len;
            beats_left_nxt = head_len[1:0] - 2'd1;
            if (head_len != 3'd1) state_nxt = S_BURST;
          end
        end
      end
      S_BURST: begin
        if (!sRx_c1TxAlmFull && head_vld) begin
          issue          = 1'b1;
          pop            = 1'b1;
          proto_set      = head.hdr.sop;
          beats_left_nxt = beats_left - 2'd1;
          if (beats_left == 2'd1) state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---- credit return ------------------------------------------------------
  logic signed [OUT_W+1:0] out_s, res_s, dec_s, out_sum;

  assign rsp_wr  = sRx_c1.rspValid && (sRx_c1.hdr.resp_type == eRSP_WRLINE);
  assign dec     = !rsp_wr          ? 3'd0 :
                   sRx_c1.hdr.format ? ({1'b0, sRx_c1.hdr.cl_num} + 3'd1) : 3'd1;
  assign out_s   = $signed({2'b00, outstanding});
  assign res_s   = $signed({{(OUT_W-1){1'b0}}, reserve});
  assign dec_s   = $signed({{(OUT_W-1){1'b0}}, dec});
  assign out_sum = out_s + res_s - dec_s;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= S_IDLE;
      beats_left  <= 2'd0;
      outstanding <= '0;
      wr_req_cnt  <= '0;
      wr_rsp_cnt  <= '0;
      ovf_error   <= 1'b0;
      proto_error <= 1'b0;
      udf_error   <= 1'b0;
    end else begin
      state       <= state_nxt;
      beats_left  <= beats_left_nxt;
      outstanding <= floor_at_zero(out_sum);
      if (issue) wr_req_cnt <= wr_req_cnt + 32'd1;
      wr_rsp_cnt  <= wr_rsp_cnt + 32'(dec);
      if (drop)        ovf_error   <= 1'b1;
      if (proto_set)   proto_error <= 1'b1;
      if (out_sum < 0) udf_error   <= 1'b1;
    end
  end

  assign outstanding_out = outstanding;

  // ---- stage p1: registered output to platform ---------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sTx_c1 <= '0;
    end else begin
      sTx_c1.valid <= issue;
      if (issue) begin
        sTx_c1.hdr  <= head.hdr;
        sTx_c1.data <= head.data;
      end
    end
  end

endmodule

// File: tb/tb_ccip_c1_tx_shaper.sv
// Directed bench for ccip_c1_tx_shaper (MAX_OUTSTANDING=8, 16-entry FIFO).
module tb_ccip_c1_tx_shaper;
  import ccip_c1_tx_shaper_pkg::*;

  logic           clk = 1'b0;
  logic           resetn;
  t_if_ccip_c1_Tx tx_in;
  logic           in_ready;
  logic           almfull;
  t_if_ccip_c1_Tx tx_out;
  t_if_ccip_c1_Rx rx;
  logic [3:0]     outstanding;
  logic [31:0]    wr_req_cnt, wr_rsp_cnt;
  logic           ovf_error, proto_error, udf_error;

  int n_vec = 0;
  int n_err = 0;
  int seen  = 0;

  ccip_c1_tx_shaper #(
    .NIC_ID(0), .LFIFO_DEPTH(4), .SKID(4), .MAX_OUTSTANDING(8)
  ) dut (
    .clk(clk), .resetn(resetn), .sTx_c1_in(tx_in), .in_ready(in_ready),
    .sRx_c1TxAlmFull(almfull), .sTx_c1(tx_out), .sRx_c1(rx),
    .outstanding_out(outstanding), .wr_req_cnt(wr_req_cnt),
    .wr_rsp_cnt(wr_rsp_cnt), .ovf_error(ovf_error),
    .proto_error(proto_error), .udf_error(udf_error)
  );

  always #5 clk = ~clk;

  // Issued-beat monitor, sampled mid-cycle.
  always @(negedge clk) if (tx_out.valid === 1'b1) seen++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_beat(input logic sop, input logic [1:0] cl_len, input logic [41:0] addr);
    tx_in              = '0;
    tx_in.valid        = 1'b1;
    tx_in.hdr.sop      = sop;
    tx_in.hdr.cl_len   = cl_len;
    tx_in.hdr.req_type = eREQ_WRLINE_I;
    tx_in.hdr.address  = addr;
    tx_in.data         = {8{22'h0, addr}};
    tick();
    tx_in.valid = 1'b0;
  endtask

  task automatic set_rsp(input t_ccip_c1_rsp t, input logic fmt, input logic [1:0] cl);
    rx                = '0;
    rx.rspValid       = 1'b1;
    rx.hdr.resp_type  = t;
    rx.hdr.format     = fmt;
    rx.hdr.cl_num     = cl;
  endtask

  task automatic rsp(input logic fmt, input logic [1:0] cl);
    set_rsp(eRSP_WRLINE, fmt, cl);
    tick();
    rx = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn  = 1'b0;
    tx_in   = '0;
    almfull = 1'b0;
    rx      = '0;
    repeat (2) tick();
    check("rst_valid", 64'(tx_out.valid), 64'd0);
    check("rst_hdr", 64'(tx_out.hdr.address), 64'd0);
    check("rst_outstanding", 64'(outstanding), 64'd0);
    check("rst_counters", {wr_req_cnt, wr_rsp_cnt}, 64'd0);
    check("rst_errors", 64'({ovf_error, proto_error, udf_error}), 64'd0);
    resetn = 1'b1;
    tick();
    check("rst_in_ready", 64'(in_ready), 64'd1);

    // 1-CL write: visible after the third edge, one cycle wide.
    drive_beat(1'b1, 2'd0, 42'h100);
    check("t1_lat_k", 64'(tx_out.valid), 64'd0);
    tick();
    check("t1_lat_k1", 64'(tx_out.valid), 64'd0);
    tick();
    check("t1_valid", 64'(tx_out.valid), 64'd1);
    check("t1_addr", 64'(tx_out.hdr.address), 64'h100);
    check("t1_data", tx_out.data[63:0], 64'h100);
    check("t1_data_hi", tx_out.data[511:448], 64'h100);
    check("t1_outstanding", 64'(outstanding), 64'd1);
    check("t1_req_cnt", 64'(wr_req_cnt), 64'd1);
    tick();
    check("t1_one_cycle", 64'(tx_out.valid), 64'd0);
    rsp(1'b0, 2'd0);
    check("t1_rsp_outstanding", 64'(outstanding), 64'd0);
    check("t1_rsp_cnt", 64'(wr_rsp_cnt), 64'd1);

    // 4-CL batch, almost-full raised after beat 2 for 5 cycles.
    drive_beat(1'b1, 2'd3, 42'h200);
    drive_beat(1'b0, 2'd3, 42'h240);
    check("t2_pre", 64'(tx_out.valid), 64'd0);
    drive_beat(1'b0, 2'd3, 42'h280);
    check("t2_b0", {31'd0, tx_out.valid, 16'd0, 7'd0, tx_out.hdr.sop, 8'(tx_out.hdr.address)}, {31'd0, 1'b1, 16'd0, 7'd0, 1'b1, 8'h00});
    check("t2_b0_addr", 64'(tx_out.hdr.address), 64'h200);
    check("t2_reserve", 64'(outstanding), 64'd4);
    drive_beat(1'b0, 2'd3, 42'h2C0);
    check("t2_b1_valid", 64'(tx_out.valid), 64'd1);
    check("t2_b1_sop", 64'(tx_out.hdr.sop), 64'd0);
    check("t2_b1_addr", 64'(tx_out.hdr.address), 64'h240);
    check("t2_b1_outstanding", 64'(outstanding), 64'd4);
    almfull = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t2_hold", 64'(tx_out.valid), 64'd0);
    end
    almfull = 1'b0;
    tick();
    check("t2_b2_valid", 64'(tx_out.valid), 64'd1);
    check("t2_b2_addr", 64'(tx_out.hdr.address), 64'h280);
    check("t2_b2_sop", 64'(tx_out.hdr.sop), 64'd0);
    tick();
    check("t2_b3_valid", 64'(tx_out.valid), 64'd1);
    check("t2_b3_addr", 64'(tx_out.hdr.address), 64'h2C0);
    check("t2_req_cnt", 64'(wr_req_cnt), 64'd5);
    tick();
    check("t2_done", 64'(tx_out.valid), 64'd0);
    rsp(1'b1, 2'd3);
    check("t2_rsp_outstanding", 64'(outstanding), 64'd0);
    check("t2_rsp_cnt", 64'(wr_rsp_cnt), 64'd5);

    // Three 4-CL batches against 8 credits: third batch stalls.
    for (int i = 0; i < 12; i++)
      drive_beat((i % 4) == 0, 2'd3, 42'h1000 + 42'(i) * 42'h40);
    repeat (4) tick();
    check("t3_seen", 64'(seen), 64'd13);
    check("t3_req_cnt", 64'(wr_req_cnt), 64'd13);
    check("t3_outstanding", 64'(outstanding), 64'd8);
    check("t3_stalled", 64'(tx_out.valid), 64'd0);
    rsp(1'b1, 2'd3);
    check("t3_rsp_outstanding", 64'(outstanding), 64'd4);
    tick();
    check("t3_c0_valid", 64'(tx_out.valid), 64'd1);
    check("t3_c0_addr", 64'(tx_out.hdr.address), 64'h1200);
    check("t3_c0_outstanding", 64'(outstanding), 64'd8);
    repeat (4) tick();
    check("t3_seen_end", 64'(seen), 64'd17);
    check("t3_counts", {wr_req_cnt, wr_rsp_cnt}, {32'd17, 32'd9});

    // Same-cycle reserve and return.
    rsp(1'b1, 2'd3);
    check("t4_pre_outstanding", 64'(outstanding), 64'd4);
    drive_beat(1'b1, 2'd0, 42'h3000);
    tick();
    set_rsp(eRSP_WRLINE, 1'b0, 2'd0);
    tick();
    rx = '0;
    check("t4_valid", 64'(tx_out.valid), 64'd1);
    check("t4_outstanding", 64'(outstanding), 64'd4);
    check("t4_counts", {wr_req_cnt, wr_rsp_cnt}, {32'd18, 32'd14});
    rsp(1'b1, 2'd3);
    check("t4_drain", 64'(outstanding), 64'd0);

    // Non-write responses are ignored; a write response at zero underflows.
    set_rsp(eRSP_WRFENCE, 1'b0, 2'd0);
    tick();
    rx = '0;
    check("ign_rsp", {32'(outstanding), wr_rsp_cnt}, {32'd0, 32'd18});
    check("ign_udf", 64'(udf_error), 64'd0);
    rsp(1'b0, 2'd0);
    check("udf_outstanding", 64'(outstanding), 64'd0);
    check("udf_flag", 64'(udf_error), 64'd1);
    check("udf_rsp_cnt", 64'(wr_rsp_cnt), 64'd19);

    // Orphan continuation beat is dropped.
    drive_beat(1'b0, 2'd0, 42'h4000);
    repeat (3) tick();
    check("proto_flag", 64'(proto_error), 64'd1);
    check("proto_no_issue", 64'(seen), 64'd18);
    check("proto_req_cnt", 64'(wr_req_cnt), 64'd18);

    // Fill under almost-full: in_ready drops at 13, 17th beat overflows.
    almfull = 1'b1;
    for (int i = 0; i < 17; i++) begin
      drive_beat(1'b1, 2'd0, 42'h5000 + 42'(i) * 42'h40);
      if (i == 12) check("ovf_ready_12", 64'(in_ready), 64'd1);
      if (i == 13) check("ovf_ready_13", 64'(in_ready), 64'd0);
      if (i == 16) check("ovf_before", 64'(ovf_error), 64'd0);
    end
    tick();
    check("ovf_set", 64'(ovf_error), 64'd1);
    almfull = 1'b0;
    repeat (12) tick();
    check("ovf_seen8", 64'(seen), 64'd26);
    check("ovf_outstanding8", 64'(outstanding), 64'd8);
    check("ovf_sticky", 64'(ovf_error), 64'd1);
    rsp(1'b1, 2'd3);
    rsp(1'b1, 2'd3);
    repeat (12) tick();
    check("ovf_seen16", 64'(seen), 64'd34);
    check("ovf_req_cnt", 64'(wr_req_cnt), 64'd34);
    check("ovf_last_addr", 64'(tx_out.hdr.address), 64'h53C0);
    check("ovf_empty", 64'(in_ready), 64'd1);
    rsp(1'b1, 2'd3);
    rsp(1'b1, 2'd3);
    check("ovf_drain", {32'(outstanding), wr_rsp_cnt}, {32'd0, 32'd35});

    // Reset in the middle of a 4-CL batch.
    drive_beat(1'b1, 2'd3, 42'h6000);
    drive_beat(1'b0, 2'd3, 42'h6040);
    drive_beat(1'b0, 2'd3, 42'h6080);
    drive_beat(1'b0, 2'd3, 42'h60C0);
    check("mr_b1_addr", 64'(tx_out.hdr.address), 64'h6040);
    check("mr_b1_outstanding", 64'(outstanding), 64'd4);
    resetn = 1'b0;
    #1;
    check("mr_valid", 64'(tx_out.valid), 64'd0);
    check("mr_outstanding", 64'(outstanding), 64'd0);
    check("mr_counters", {wr_req_cnt, wr_rsp_cnt}, 64'd0);
    check("mr_errors", 64'({ovf_error, proto_error, udf_error}), 64'd0);
    tick();
    resetn = 1'b1;
    repeat (3) tick();
    check("mr_flushed", 64'(tx_out.valid), 64'd0);
    check("mr_flushed_cnt", 64'(wr_req_cnt), 64'd0);
    drive_beat(1'b1, 2'd1, 42'h7000);
    drive_beat(1'b0, 2'd1, 42'h7040);
    tick();
    check("mr_n0_valid", 64'(tx_out.valid), 64'd1);
    check("mr_n0_addr", 64'(tx_out.hdr.address), 64'h7000);
    check("mr_n0_outstanding", 64'(outstanding), 64'd2);
    tick();
    check("mr_n1_addr", 64'(tx_out.hdr.address), 64'h7040);
    check("mr_n1_sop", 64'(tx_out.hdr.sop), 64'd0);
    tick();
    check("mr_end", {32'(tx_out.valid), wr_req_cnt}, {32'd0, 32'd2});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ccip_c1_tx_shaper.md
Name: ccip_c1_tx_shaper

Overview:
- Sits directly downstream of the CCI-P transmitter, between its sTx_c1 output and the platform c1 TX channel.
- Buffers write beats in a FIFO and holds them while sRx_c1TxAlmFull is asserted, so no beat is ever lost to channel backpressure.
- Limits outstanding eREQ_WRLINE_I cache lines with a credit counter that is decremented by c1 write responses.
- Keeps multi-CL batches atomic with respect to credit reservation and reports request/response statistics and sticky errors.

Parameters:
- NIC_ID, 0, NIC instance index (used only in $display messages).
- LFIFO_DEPTH, 4, log2 of beat FIFO depth (16 entries).
- SKID, 4, free entries required for in_ready=1; covers transmitter output latency.
- MAX_OUTSTANDING, 64, maximum cache lines written but not yet acknowledged; must be ≥4.

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous, active-low reset.
- sTx_c1_in  in  $bits(t_if_ccip_c1_Tx)  write beats from transmitter (valid, hdr, data).
- in_ready  out  1  1 when FIFO free entries ≥ SKID.
- sRx_c1TxAlmFull  in  1  platform c1 almost-full.
- sTx_c1  out  $bits(t_if_ccip_c1_Tx)  registered beats to platform.
- sRx_c1  in  $bits(t_if_ccip_c1_Rx)  c1 responses (rspValid, hdr.resp_type, hdr.format, hdr.cl_num).
- outstanding_out  out  $clog2(MAX_OUTSTANDING)+1  current outstanding CL count.
- wr_req_cnt  out  32  beats issued, wrapping.
- wr_rsp_cnt  out  32  CLs acknowledged, wrapping.
- ovf_error  out  1  sticky: push while FIFO full.
- proto_error  out  1  sticky: non-sop beat at FIFO head while idle.
- udf_error  out  1  sticky: response received with outstanding=0.

Behaviour:
- Reset (resetn=0, async): sTx_c1.valid=0, hdr/data=0, FIFO empty, state=S_IDLE, outstanding/counters=0, all errors=0, in_ready=1 once resetn=1. Reset mid-burst discards FIFO contents and in-flight credits.
- Push: every sTx_c1_in.valid=1 beat is written to the FIFO regardless of in_ready. If the FIFO is full, the beat is dropped and ovf_error is set.
- in_ready is combinational from the registered FIFO count.
- Latency: a beat sampled at edge k with an empty FIFO, state S_IDLE, almFull=0 and sufficient credits drives sTx_c1.valid=1 during the cycle after edge k+2. Throughput is 1 beat/cycle.
- sTx_c1 is registered. valid is 1 for exactly one cycle per issued beat. hdr and data are passed through unmodified, with no address or sop rewriting.
- State machine:
  - S_IDLE:
    - Head not valid → stay.
    - Head valid with sop=0 → pop, drop, set proto_error, stay.
    - Head valid with sop=1, len=hdr.cl_len+1 (1/2/4), almFull=0, outstanding+len ≤ MAX_OUTSTANDING → issue beat, outstanding += len (the whole batch is reserved), beats_left=len-1. Go to S_BURST if len>1.
    - Otherwise stall; the head is held.
  - S_BURST:
    - almFull=0 and head valid → issue beat, beats_left--, no credit change. When beats_left reaches 0 → S_IDLE.
    - almFull=1 or FIFO empty → hold, no beat.
    - A sop=1 beat arriving in S_BURST is issued as-is with proto_error set (the transmitter guarantees this does not happen).
- Responses: when rspValid=1 and resp_type=eRSP_WRLINE, dec = format ? cl_num+1 : 1. Other resp_types are ignored.
- Outstanding update each cycle: outstanding = outstanding + reserve − dec, with reserve and dec evaluated in the same cycle. If the result would go below 0, it saturates at 0 and udf_error is set.
- wr_req_cnt increments per issued beat. wr_rsp_cnt += dec, using the unsaturated value.
- Arithmetic: outstanding is sized to hold MAX_OUTSTANDING exactly; all comparisons are unsigned and zero-extended.
- FIFO: count wraps internally with standard full/empty; simultaneous push and pop at full is permitted (the pop frees the slot, so there is no drop).

Test Plan:
- 1-CL write, sop=1, addr=0x100, almFull=0 → sTx_c1.valid one cycle after edge k+2, outstanding=1. Then rsp format=0 → outstanding=0, wr_rsp_cnt=1.
- 4-CL batch, almFull raised after beat 2 for 5 cycles → beats 3–4 held, then issued back-to-back with sop only on beat 1. outstanding=4 reserved at beat 1.
- MAX_OUTSTANDING=8, three 4-CL batches, no responses → 8 beats issued, third batch stalls. Packed rsp format=1, cl_num=3 → outstanding 8→4, third batch issues, outstanding=8.
- outstanding=4, 1-CL issue and 1-CL rsp in the same cycle → outstanding stays 4, wr_req_cnt and wr_rsp_cnt each +1.
- almFull held, 17 beats pushed → in_ready=0 at occupancy 13, 17th beat dropped, ovf_error=1 and stays set after almFull clears; 16 beats issued.
- resetn pulsed low after beat 2 of a 4-CL batch → sTx_c1.valid=0 immediately, outstanding=0, FIFO empty. The next sop batch issues normally.
